// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops (AND/OR/NOR/ADD/SUB/LUI/JAL) finish one cycle after accept.
// Logical shifts (SLL/SRL) run one bit per cycle.
// The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE, never during reset)
//   alu_operation       000 AND, 001 OR, 010 NOR, 011 ADD, 100 SUB, 101 LUI, 110 JAL, 111 illegal
//   shift_en            shift request; takes priority over alu_operation
//   shift_dir           0 = SLL, 1 = SRL (zero fill)
//   shamt               shift amount
//   a_data, b_data      operands (a holds PC+4 for JAL, b is the value to shift)
//   out_valid/out_ready result handshake
//   result, zero        registered result and result==0 flag
//   illegal_op          completed op had code 111 with shift_en low
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             alu_operation,
  input  logic                   shift_en,
  input  logic                   shift_dir,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  a_data,
  input  logic [DATA_WIDTH-1:0]  b_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   illegal_op
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  op_res;

  assign shifted    = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign in_ready   = (state_q == StIdle) && !reset;
  assign out_valid  = (state_q == StDone);
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

  // Single-cycle datapath; code 111 yields 0.
  always_comb begin
    op_res = '0;
    case (alu_operation)
      3'b000:  op_res = a_data & b_data;
      3'b001:  op_res = a_data | b_data;
      3'b010:  op_res = ~(a_data | b_data);
      3'b011:  op_res = a_data + b_data;
      3'b100:  op_res = a_data - b_data;
      3'b101:  op_res = b_data << 16;
      3'b110:  op_res = a_data + DATA_WIDTH'(4);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          if (shift_en) begin
            dir_d = shift_dir;
            if (shamt == '0) begin
              result_d  = b_data;
              zero_d    = (b_data == '0);
              illegal_d = 1'b0;
              state_d   = StDone;
            end else begin
              shreg_d = b_data;
              cnt_d   = shamt;
              state_d = StShift;
            end
          end else begin
            result_d  = op_res;
            zero_d    = (op_res == '0);
            illegal_d = (alu_operation == 3'b111);
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - SHAMT_WIDTH'(1);
        // Last bit: latch straight from the shifter so latency is shamt+1.
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d  = shifted;
          zero_d    = (shifted == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [2:0]    alu_operation;
  logic          shift_en, shift_dir;
  logic [SW-1:0] shamt;
  logic [DW-1:0] a_data, b_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] result;
  logic          zero, illegal_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_operation(alu_operation), .shift_en(shift_en), .shift_dir(shift_dir),
    .shamt(shamt), .a_data(a_data), .b_data(b_data), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal_op(illegal_op)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {illegal, result} straight from the operation definitions.
  function automatic logic [DW:0] model(input logic se, input logic dir, input logic [SW-1:0] sa,
                                        input logic [2:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          ill;
    ill = 1'b0;
    if (se) begin
      r = dir ? (b >> sa) : (b << sa);
    end else begin
      case (op)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = ~(a | b);
        3'd3: r = a + b;
        3'd4: r = a - b;
        3'd5: r = {b[15:0], 16'h0000};
        3'd6: r = a + 32'd4;
        default: begin r = '0; ill = 1'b1; end
      endcase
    end
    return {ill, r};
  endfunction

  task automatic run_op(input string tag, input logic se, input logic dir, input logic [SW-1:0] sa,
                        input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int hold);
    logic [DW:0]   exp;
    logic [DW-1:0] exp_r;
    logic          acc;
    int            lat, exp_lat;
    exp     = model(se, dir, sa, op, a, b);
    exp_r   = exp[DW-1:0];
    exp_lat = (se && sa != 0) ? int'(sa) + 1 : 1;
    @(negedge clk);
    shift_en = se; shift_dir = dir; shamt = sa; alu_operation = op;
    a_data = a; b_data = b; in_valid = 1'b1; out_ready = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (i > 0) @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (!acc) begin
      check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Inputs change after accept; the unit must ignore them.
    in_valid = 1'b0;
    a_data = $urandom; b_data = $urandom; shamt = SW'($urandom);
    alu_operation = 3'($urandom); shift_en = 1'($urandom); shift_dir = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_result"}, 64'(result), 64'(exp_r));
    check_eq({tag, "_zero"}, 64'(zero), 64'(exp_r == '0));
    check_eq({tag, "_illegal"}, 64'(illegal_op), 64'(exp[DW]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_result"}, 64'(result), 64'(exp_r));
      check_eq({tag, "_hold_ready"}, {63'd0, in_ready, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_after_hs"}, {63'd0, in_ready, out_valid}, 64'd2);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_operation = '0;
    shift_en = 1'b0; shift_dir = 1'b0; shamt = '0; a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_flags", {62'd0, zero, illegal_op}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);

    run_op("add_5_7", 0, 0, 0, 3'd3, 32'd5, 32'd7, 0);
    run_op("sub_eq", 0, 0, 0, 3'd4, 32'd7, 32'd7, 0);
    run_op("sub_wrap", 0, 0, 0, 3'd4, 32'd0, 32'd1, 0);
    run_op("lui", 0, 0, 0, 3'd5, 32'd0, 32'h0000_1234, 0);
    run_op("jal", 0, 0, 0, 3'd6, 32'h0040_0004, 32'd0, 0);
    run_op("sll31", 1, 0, 5'd31, 3'd0, 32'd0, 32'd1, 0);
    run_op("srl0", 1, 1, 5'd0, 3'd0, 32'd0, 32'h8000_0000, 0);
    run_op("backpressure", 0, 0, 0, 3'd1, 32'h00F0, 32'h0F00, 5);
    run_op("illegal", 0, 0, 0, 3'd7, 32'h1234, 32'h5678, 1);
    run_op("add_after_ill", 0, 0, 0, 3'd3, 32'h10, 32'h20, 0);

    // Reset in the middle of a long shift discards it.
    @(negedge clk);
    shift_en = 1'b1; shift_dir = 1'b0; shamt = 5'd20; b_data = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("midshift_busy", {63'd0, in_ready, out_valid}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midshift_rst", {63'd0, in_ready, out_valid}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midshift_idle", {63'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("midshift_discard", 64'(seen), 64'd0);
    run_op("add_after_rst", 0, 0, 0, 3'd3, 32'hFFFF_FFFF, 32'd1, 0);

    for (int n = 0; n < 60; n++) begin
      logic se;
      se = 1'($urandom);
      run_op($sformatf("rand%0d", n), se, 1'($urandom), SW'($urandom), 3'($urandom),
             $urandom, (n % 7 == 0) ? 32'd0 : $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
